dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core's memory stage: the slave end of the core's load/store port. It accepts one word-wide request at a time (address, byte selects, write data), inserts a programmable number of wait states, commits byte-enabled writes or returns full read words, and raises `stall` back to the hazard unit while an access is outstanding. Load byte/halfword extraction and sign extension stay in the core's writeback stage; this block always returns the full 32-bit word.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_ram.sv | 29 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_e   : responder FSM states
//   CNT_W     : wait-state counter width (WAIT_CYCLES range 0..15)
//   DATA_W    : bus word width
//   SEL_*     : common byte-lane select patterns for stores
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

  localparam logic [3:0] SEL_WORD  = 4'b1111;
  localparam logic [3:0] SEL_HALF0 = 4'b0011;
  localparam logic [3:0] SEL_HALF1 = 4'b1100;

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the core's memory stage (master) and the
// data-memory responder (slave).
//   req_en/req_we/req_addr/req_sel/req_wdata : request from the core
//   rsp_rdata/rsp_err                        : response, valid in DONE
//   stall                                    : hold request to the hazard unit
interface dmem_if;
  import dmem_pkg::*;

  logic              req_en;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [3:0]        req_sel;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall;

  modport master (
    output req_en, req_we, req_addr, req_sel, req_wdata,
    input  rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_en, req_we, req_addr, req_sel, req_wdata,
    output rsp_rdata, rsp_err, stall
  );

endinterface

// File: rtl/dmem_ram.sv
// Word-wide single-port synchronous RAM with per-byte write enables.
//   clk   : clock
//   we    : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   addr  : word index
//   wdata : write word
//   rdata : registered read word (old contents on a same-cycle write)
// Contents are not reset.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the core's load/store port.
// Accepts one request at a time, inserts WAIT_CYCLES wait states,
// commits byte-enabled stores or returns full read words, and holds
// the pipeline via stall while an access is outstanding.
//   clk, rst : clock, synchronous active-high reset
//   bus      : dmem_if slave modport (request in, response/stall out)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  state_e            state;
  state_e            stateNext;
  logic [CNT_W-1:0]  cnt;

  logic              latWe;
  logic [31:2]       latWord;
  logic [3:0]        latSel;
  logic [DATA_W-1:0] latWdata;

  logic              accessNow;
  logic              inRange;
  logic [ADDR_W-1:0] ramAddr;
  logic [3:0]        ramWe;
  logic [DATA_W-1:0] ramRdata;

  // Every byte-address bit above the memory's index field must be zero.
  assign inRange = (latWord >> ADDR_W) == '0;

  // The RAM read is registered, so it is addressed from the live request
  // while IDLE; the word for the latched address is then already on
  // ramRdata in the first WAIT cycle, which covers WAIT_CYCLES = 0.
  assign ramAddr = (state == IDLE) ? bus.req_addr[ADDR_W+1:2]
                                   : latWord[ADDR_W+1:2];
  assign ramWe   = (accessNow && latWe && inRange) ? latSel : 4'b0000;

  dmem_ram #(.ADDR_W(ADDR_W)) uRam (
    .clk   (clk),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (latWdata),
    .rdata (ramRdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.req_en) stateNext = WAIT;
      WAIT:    if (cnt == '0)  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs; rst masks both so a pending store is abandoned.
  always_comb begin
    accessNow = 1'b0;
    bus.stall = 1'b0;
    if (!rst) begin
      accessNow = (state == WAIT) && (cnt == '0);
      bus.stall = ((state == IDLE) && bus.req_en) || (state == WAIT);
    end
  end

  // Wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && bus.req_en) begin
      cnt <= CNT_W'(WAIT_CYCLES);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Request latch: held for the whole access, so a flush cannot abort it.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_en) begin
      latWe    <= bus.req_we;
      latWord  <= bus.req_addr[31:2];
      latSel   <= bus.req_sel;
      latWdata <= bus.req_wdata;
    end
  end

  // Response registers: rdata only changes on a completed load or error.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accessNow) begin
      if (!inRange) begin
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end else if (!latWe) begin
        bus.rsp_rdata <= ramRdata;
      end
    end else if (state == DONE) begin
      bus.rsp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int AW = 10;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  dmem_if bus();

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one access starting in IDLE; returns sampled in DONE with req_en still high.
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] wdata,
                        input logic [31:0] expRdata, input logic expErr);
    int n;
    @(posedge clk); #1;
    bus.req_en = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_sel = sel; bus.req_wdata = wdata;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check({name, " stallCycles"}, 32'(n), 32'(WC + 2));
    check({name, " rdata"}, bus.rsp_rdata, expRdata);
    check({name, " err"}, 32'(bus.rsp_err), 32'(expErr));
  endtask

  task automatic idle(input string name);
    bus.req_en = 1'b0;
    @(posedge clk); #1;
    check({name, " idleStall"}, 32'(bus.stall), 32'd0);
    check({name, " idleErrClr"}, 32'(bus.rsp_err), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 32'h0000_0000, SEL_WORD,  32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, SEL_WORD,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 4'b0000,   32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 4'b0010,   32'h0000_AA00, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 4'b0000,   32'h0,         32'hDEAD_AAEF, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0010, SEL_HALF1, 32'h1234_0000, 32'hDEAD_AAEF, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 4'b0000,   32'h0,         32'h1234_AAEF, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_1000, 4'b0000,   32'h0,         32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_1000, SEL_WORD,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 4'b0000,   32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0FFC, SEL_WORD,  32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_0FFC, 4'b0000,   32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0010, 4'b0000,   32'h0,         32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0010, 4'b0000,   32'h0,         32'h1234_AAEF, 1'b0};

    // Reset state, with a request present to confirm stall is masked.
    rst = 1'b1;
    bus.req_en = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10;
    bus.req_sel = 4'b0; bus.req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset rdata", bus.rsp_rdata, 32'd0);
    check("reset err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0; bus.req_en = 1'b0;

    for (int i = 0; i < 14; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].sel,
             vecs[i].wdata, vecs[i].expRdata, vecs[i].expErr);
      idle($sformatf("vec%0d", i));
    end

    // Flush: req_en dropped once the store is in WAIT.
    @(posedge clk); #1;
    bus.req_en = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_sel = SEL_WORD; bus.req_wdata = 32'h1122_3344;
    #1;
    n = 0;
    while (bus.stall === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
      bus.req_en = 1'b0;
      #1;
    end
    check("flush stallCycles", 32'(n), 32'(WC + 2));
    idle("flush");
    access("flushLoad", 1'b0, 32'h20, 4'b0, 32'h0, 32'h1122_3344, 1'b0);
    idle("flushLoad");

    // Reset in the middle of a store: old contents must survive.
    access("rstSeed", 1'b1, 32'h30, SEL_WORD, 32'h0BAD_CAFE, 32'h1122_3344, 1'b0);
    idle("rstSeed");
    access("rstPre", 1'b0, 32'h30, 4'b0, 32'h0, 32'h0BAD_CAFE, 1'b0);
    idle("rstPre");
    @(posedge clk); #1;
    bus.req_en = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h30;
    bus.req_sel = SEL_WORD; bus.req_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    check("rstMid waitStall", 32'(bus.stall), 32'd1);
    rst = 1'b1; bus.req_en = 1'b0;
    #1;
    check("rstMid stallMasked", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check("rstMid stall", 32'(bus.stall), 32'd0);
    check("rstMid rdata", bus.rsp_rdata, 32'd0);
    check("rstMid err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check("rstMid idle", 32'(bus.stall), 32'd0);
    access("rstPost", 1'b0, 32'h30, 4'b0, 32'h0, 32'h0BAD_CAFE, 1'b0);
    idle("rstPost");

    // Back-to-back: req_en held from store straight into load.
    access("b2bStore", 1'b1, 32'h40, SEL_WORD, 32'h89AB_CDEF, 32'h0BAD_CAFE, 1'b0);
    access("b2bLoad", 1'b0, 32'h40, 4'b0, 32'h0, 32'h89AB_CDEF, 1'b0);
    idle("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
